// File: rtl/period_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter_pkg
//  Description : Shared types and default constants for the period meter.
//                The meter top (period_meter) honours the optional macro
//                PERIOD_METER_CONT_EN for back-to-back measurement.
//  Revision    : 1.0 - initial release
// ============================================================================
package period_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } pm_state_t;

    // Default counter width and give-up limit (2 s at 50 MHz)
    localparam int CNT_W_DEFAULT       = 32;
    localparam int TIMEOUT_CYC_DEFAULT = 100_000_000;

endpackage : period_meter_pkg
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : edge_sync
//  Description : SYNC_STAGES-deep synchronizer for an asynchronous input,
//                followed by a registered rising-edge detector. The level
//                output q_sync is aligned with rise: in the cycle rise is
//                high, q_sync is already 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   last;

    // Shift the pin through the synchronizer and flag a 0->1 transition
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_ff <= '0;
            last    <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
            last    <= sync_ff[SYNC_STAGES-1];
            rise    <= sync_ff[SYNC_STAGES-1] & ~last;
        end
    end

    assign q_sync = last;

endmodule : edge_sync
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter
//  Description : Measures period and high time of a slow asynchronous square
//                wave in system-clock cycles. Single-shot by default; with
//                PERIOD_METER_CONT_EN defined, consecutive periods are
//                published back-to-back until a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    // Last count value before giving up in ARM or MEASURE
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

    logic             rise;
    logic             level;
    pm_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clock  (clock),
        .reset  (reset),
        .d      (sig_in),
        .q_sync (level),
        .rise   (rise)
    );

    // Measurement FSM with its counters and registered result/strobe outputs.
    // The rise cycle itself counts as cycle 1 of the new period (and is high),
    // so a wave of N clocks yields period == N.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // A rise coinciding with start is not acted on here
                    if (start) begin
                        state <= ARM;
                        cnt   <= '0;
                        hcnt  <= '0;
                    end
                end
                ARM: begin
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= ONE;
                        hcnt  <= ONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period    <= cnt;
                        high_time <= hcnt;
                        valid     <= 1'b1;
`ifdef PERIOD_METER_CONT_EN
                        cnt       <= ONE;
                        hcnt      <= ONE;
`else
                        state     <= IDLE;
`endif
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                        if (level) begin
                            hcnt <= hcnt + ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule : period_meter
`default_nettype wire
